// File: rtl/ras_ctrl.sv
// Return-address-stack controller: classifies calls/returns, drives call_stack push/pop,
// registers the predicted return target and keeps saturating hit/miss/overflow statistics.
module ras_ctrl #(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [AW-1:0] i_pc,
    input  logic          i_is_call,
    input  logic          i_is_ret,
    input  logic          i_is_rvc,
    input  logic          i_flush,
    output logic          o_push_en,
    output logic [AW-1:0] o_push_data,
    output logic          o_pop_en,
    input  logic [AW-1:0] i_pop_data,
    input  logic          i_empty,
    input  logic          i_full,
    output logic          o_pred_valid,
    output logic [AW-1:0] o_pred_target,
    output logic          o_pred_hit,
    output logic [CW-1:0] o_hit_cnt,
    output logic [CW-1:0] o_miss_cnt,
    output logic [CW-1:0] o_ovf_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state, state_next;

    logic accept;
    logic call_acc;
    logic ret_acc;

    // Link address wraps modulo 2^AW; no carry out is kept.
    assign o_push_data = i_pc + (i_is_rvc ? AW'(2) : AW'(4));

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_push_en  = 1'b0;
        o_pop_en   = 1'b0;
        accept     = 1'b0;
        call_acc   = 1'b0;
        ret_acc    = 1'b0;
        case (state)
            RUN: begin
                o_ready   = 1'b1;
                accept    = i_valid & ~i_flush;
                call_acc  = accept & i_is_call;
                ret_acc   = accept & i_is_ret;
                o_push_en = call_acc;
                o_pop_en  = ret_acc & ~i_empty;
                if (i_flush && !i_empty)
                    state_next = DRAIN;
            end
            DRAIN: begin
                // One pop per cycle; the cycle that sees empty still holds off new ops.
                o_pop_en = ~i_empty;
                if (i_empty)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            o_pred_valid  <= 1'b0;
            o_pred_target <= '0;
            o_pred_hit    <= 1'b0;
            o_hit_cnt     <= '0;
            o_miss_cnt    <= '0;
            o_ovf_cnt     <= '0;
        end else begin
            state        <= state_next;
            o_pred_valid <= ret_acc;
            if (ret_acc) begin
                o_pred_target <= i_empty ? '0 : i_pop_data;
                o_pred_hit    <= ~i_empty;
                if (!i_empty && o_hit_cnt != '1)
                    o_hit_cnt <= o_hit_cnt + CW'(1);
                if (i_empty && o_miss_cnt != '1)
                    o_miss_cnt <= o_miss_cnt + CW'(1);
            end
            if (call_acc && i_full && o_ovf_cnt != '1)
                o_ovf_cnt <= o_ovf_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with a small 4-deep call_stack model feeding pop data/empty/full.
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, is_call, is_ret, is_rvc, flush;
    logic [31:0] pc;
    logic        ready, push_en, pop_en;
    logic [31:0] push_data;
    logic [31:0] pop_data;
    logic        empty, full;
    logic        pred_valid, pred_hit;
    logic [31:0] pred_target;
    logic [15:0] hit_cnt, miss_cnt, ovf_cnt;

    logic        s_ready, s_push_en, s_pop_en, s_pred_valid, s_pred_hit;
    logic [31:0] s_push_data, s_pred_target;
    logic [1:0]  s_hit_cnt, s_miss_cnt, s_ovf_cnt;

    int checks = 0;
    int fails  = 0;

    logic [31:0] stk [0:3];
    int          cnt;

    always #5 clk = ~clk;

    ras_ctrl #(.AW(32), .CW(16)) dut (
        .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready), .i_pc(pc),
        .i_is_call(is_call), .i_is_ret(is_ret), .i_is_rvc(is_rvc), .i_flush(flush),
        .o_push_en(push_en), .o_push_data(push_data), .o_pop_en(pop_en),
        .i_pop_data(pop_data), .i_empty(empty), .i_full(full),
        .o_pred_valid(pred_valid), .o_pred_target(pred_target), .o_pred_hit(pred_hit),
        .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt), .o_ovf_cnt(ovf_cnt)
    );

    ras_ctrl #(.AW(32), .CW(2)) dut_s (
        .clk(clk), .rst(rst), .i_valid(valid), .o_ready(s_ready), .i_pc(pc),
        .i_is_call(is_call), .i_is_ret(is_ret), .i_is_rvc(is_rvc), .i_flush(flush),
        .o_push_en(s_push_en), .o_push_data(s_push_data), .o_pop_en(s_pop_en),
        .i_pop_data(pop_data), .i_empty(empty), .i_full(full),
        .o_pred_valid(s_pred_valid), .o_pred_target(s_pred_target), .o_pred_hit(s_pred_hit),
        .o_hit_cnt(s_hit_cnt), .o_miss_cnt(s_miss_cnt), .o_ovf_cnt(s_ovf_cnt)
    );

    // call_stack model: push+pop overwrites top, push while full drops the oldest entry.
    assign empty    = (cnt == 0);
    assign full     = (cnt == 4);
    assign pop_data = (cnt == 0) ? 32'h0 : stk[cnt-1];

    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0;
        end else if (push_en && pop_en) begin
            stk[cnt-1] <= push_data;
        end else if (push_en) begin
            if (cnt == 4) begin
                stk[0] <= stk[1];
                stk[1] <= stk[2];
                stk[2] <= stk[3];
                stk[3] <= push_data;
            end else begin
                stk[cnt] <= push_data;
                cnt      <= cnt + 1;
            end
        end else if (pop_en && cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    task automatic drive(input logic v, input logic c, input logic r, input logic rvc,
                         input logic [31:0] p, input logic f);
        valid = v; is_call = c; is_ret = r; is_rvc = rvc; pc = p; flush = f;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (pred_valid !== 1'b0) begin fails++; $display("FAIL reset_pred_valid got %b want 0", pred_valid); end
        checks++; if (pred_target !== 32'h0) begin fails++; $display("FAIL reset_target got %h want 0", pred_target); end
        checks++; if ({hit_cnt, miss_cnt, ovf_cnt} !== 48'h0) begin fails++; $display("FAIL reset_counters got %h/%h/%h want 0", hit_cnt, miss_cnt, ovf_cnt); end
    endtask

    task automatic test_call_ret();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0);
        #1;
        checks++; if (push_en !== 1'b1 || pop_en !== 1'b0) begin fails++; $display("FAIL call_push_pop got %b%b want 10", push_en, pop_en); end
        checks++; if (push_data !== 32'h104) begin fails++; $display("FAIL call_push_data got %h want 00000104", push_data); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h180, 1'b0);
        #1;
        checks++; if (pop_en !== 1'b1 || push_en !== 1'b0) begin fails++; $display("FAIL ret_pop got %b%b want 10", pop_en, push_en); end
        checks++; if (pred_valid !== 1'b0) begin fails++; $display("FAIL ret_pred_early got %b want 0", pred_valid); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (pred_valid !== 1'b1 || pred_hit !== 1'b1) begin fails++; $display("FAIL ret_pred got v=%b h=%b want 1 1", pred_valid, pred_hit); end
        checks++; if (pred_target !== 32'h104) begin fails++; $display("FAIL ret_target got %h want 00000104", pred_target); end
        checks++; if (hit_cnt !== 16'd1) begin fails++; $display("FAIL hit_cnt1 got %0d want 1", hit_cnt); end
        @(negedge clk);
        #1;
        checks++; if (pred_valid !== 1'b0 || pred_target !== 32'h104) begin fails++; $display("FAIL pred_hold got v=%b t=%h want 0 00000104", pred_valid, pred_target); end
    endtask

    task automatic test_ret_empty();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0);
        #1;
        checks++; if (pop_en !== 1'b0) begin fails++; $display("FAIL empty_pop got %b want 0", pop_en); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (pred_valid !== 1'b1 || pred_hit !== 1'b0 || pred_target !== 32'h0) begin fails++; $display("FAIL empty_pred got v=%b h=%b t=%h want 1 0 0", pred_valid, pred_hit, pred_target); end
        checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1) begin fails++; $display("FAIL miss_cnt1 got m=%0d h=%0d want 1 1", miss_cnt, hit_cnt); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        #1;
        checks++; if (push_data !== 32'h0 || push_en !== 1'b1) begin fails++; $display("FAIL wrap_push got en=%b d=%h want 1 00000000", push_en, push_data); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        checks++; if (pred_hit !== 1'b1 || pred_target !== 32'h0 || hit_cnt !== 16'd2) begin fails++; $display("FAIL wrap_pred got h=%b t=%h c=%0d want 1 0 2", pred_hit, pred_target, hit_cnt); end
    endtask

    task automatic test_call_ret_same();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0);
        #1;
        checks++; if (push_en !== 1'b1 || pop_en !== 1'b1 || push_data !== 32'h204) begin fails++; $display("FAIL cr_outputs got %b%b %h want 11 00000204", push_en, pop_en, push_data); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (pred_target !== 32'h104 || pred_hit !== 1'b1 || pred_valid !== 1'b1) begin fails++; $display("FAIL cr_pred got t=%h h=%b v=%b want 00000104 1 1", pred_target, pred_hit, pred_valid); end
        checks++; if (pop_data !== 32'h204 || cnt != 1) begin fails++; $display("FAIL cr_top got %h n=%0d want 00000204 1", pop_data, cnt); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0);
        #1;
        checks++; if (push_en !== 1'b1 || pop_en !== 1'b0 || push_data !== 32'h402) begin fails++; $display("FAIL cr_empty got %b%b %h want 10 00000402", push_en, pop_en, push_data); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (pred_hit !== 1'b0 || pred_target !== 32'h0 || miss_cnt !== 16'd2 || hit_cnt !== 16'd4) begin fails++; $display("FAIL cr_empty_pred got h=%b t=%h m=%0d c=%0d want 0 0 2 4", pred_hit, pred_target, miss_cnt, hit_cnt); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i * 16), 1'b0);
        end
        @(negedge clk);
        #1;
        checks++; if (full !== 1'b1 || ovf_cnt !== 16'd0) begin fails++; $display("FAIL ovf_pre got full=%b c=%0d want 1 0", full, ovf_cnt); end
        checks++; if (push_en !== 1'b1) begin fails++; $display("FAIL ovf_push got %b want 1", push_en); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL ovf_cnt got %0d want 1", ovf_cnt); end
    endtask

    task automatic test_flush();
        int low, pops;
        bit done;
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 1'b1);
        #1;
        checks++; if (push_en !== 1'b0 || pop_en !== 1'b0) begin fails++; $display("FAIL flush_empty_ops got %b%b want 00", push_en, pop_en); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (ready !== 1'b1 || pred_valid !== 1'b0) begin fails++; $display("FAIL flush_empty_run got r=%b v=%b want 1 0", ready, pred_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000 + 32'(i * 8), 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (pop_en !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL flush_drop got pop=%b r=%b want 0 1", pop_en, ready); end
        low = 0; pops = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h7000, 1'b0);
            #1;
            if (ready) begin
                idle();
                done = 1;
            end else begin
                low++;
                if (pop_en) pops++;
                if (push_en) begin checks++; fails++; $display("FAIL drain_push got 1 want 0"); end
                if (pred_valid && low == 1) begin checks++; fails++; $display("FAIL drain_pred got 1 want 0"); end
            end
        end
        checks++; if (!done) begin fails++; $display("FAIL drain_timeout got stuck want RUN within 20"); end
        checks++; if (low != 4 || pops != 3) begin fails++; $display("FAIL drain_counts got low=%0d pops=%0d want 4 3", low, pops); end
        checks++; if (empty !== 1'b1 || hit_cnt !== 16'd0) begin fails++; $display("FAIL drain_end got e=%b h=%0d want 1 0", empty, hit_cnt); end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
        end
        idle();
        #1;
        checks++; if (s_miss_cnt !== 2'd3) begin fails++; $display("FAIL sat_miss got %0d want 3", s_miss_cnt); end
        checks++; if (miss_cnt !== 16'd5) begin fails++; $display("FAIL wide_miss got %0d want 5", miss_cnt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        idle();
        #1;
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_drain got r=%b want 0", ready); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (ready !== 1'b1 || miss_cnt !== 16'd0 || s_miss_cnt !== 2'd0 || pred_valid !== 1'b0) begin fails++; $display("FAIL drain_reset got r=%b m=%0d s=%0d v=%b want 1 0 0 0", ready, miss_cnt, s_miss_cnt, pred_valid); end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_call_ret();
        test_ret_empty();
        test_wrap();
        test_call_ret_same();
        test_overflow();
        test_flush();
        test_saturate_reset();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
